pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a two-entry pipeline stage built from a main register and a skid register.
// The main register drives the out_* ports. The skid register catches the one entry that
// upstream may send while the stage is stalled. in_ready comes from a flop, so there is no
// combinational path from out_ready to in_ready.
//
// Handshake: an entry moves on any rising edge where valid && ready are both 1 on that side.
// A producer holds valid and its data steady until that edge. A consumer may change ready
// freely. in_valid is never qualified by in_ready, and out_valid is never qualified by out_ready.
module pipe_stage_reg #(
   parameter int          DATA_W     = 32,
   parameter int          NUM_FIELDS = 4,
   parameter logic [31:0] EXC_PC     = 32'h00004180,
   parameter int          CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_pc,
   input  logic [NUM_FIELDS*DATA_W-1:0] in_payload,
   input  logic                         flush,
   input  logic                         req,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_pc,
   output logic [NUM_FIELDS*DATA_W-1:0] out_payload,
   output logic [CNT_W-1:0]             stall_cnt
);

   localparam int               PW      = NUM_FIELDS * DATA_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Main entry: this is what the outputs show.
   logic          main_valid;
   logic [31:0]   main_pc;
   logic [PW-1:0] main_payload;

   // Skid entry: it is never visible on the outputs until it moves into main.
   logic          skid_valid;
   logic [31:0]   skid_pc;
   logic [PW-1:0] skid_payload;

   // Registered copy of !skid_valid.
   logic          in_ready_q;

   logic transfer;
   logic main_free;

   // Decode the cycle's events from registered state and the current inputs.
   always_comb begin
      transfer  = in_valid && in_ready_q;
      // main can take a new entry when it is empty or is draining this cycle
      main_free = !main_valid || out_ready;
   end

   // Main register: reset > req > flush > refill from skid > refill from input.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_valid   <= 1'b0;
         main_pc      <= 32'h0;
         main_payload <= '0;
      end else if (req) begin
         main_valid   <= 1'b0;
         main_pc      <= EXC_PC;
         main_payload <= '0;
      end else if (flush) begin
         // keep the PC of the flushed slot for exception reporting
         main_valid   <= 1'b0;
         main_pc      <= in_pc;
         main_payload <= '0;
      end else if (main_free) begin
         if (skid_valid) begin
            // the skid entry is older than anything on the input, so it goes first
            main_valid   <= 1'b1;
            main_pc      <= skid_pc;
            main_payload <= skid_payload;
         end else if (transfer) begin
            main_valid   <= 1'b1;
            main_pc      <= in_pc;
            main_payload <= in_payload;
         end else begin
            // drained with nothing behind it; pc/payload keep the last entry
            main_valid   <= 1'b0;
         end
      end
   end

   // Skid register: fills only when main is stalled, and empties whenever main is free.
   always_ff @(posedge clk) begin
      if (reset || req || flush) begin
         skid_valid   <= 1'b0;
         skid_pc      <= 32'h0;
         skid_payload <= '0;
      end else if (main_free) begin
         // either skid moved into main this cycle or it was already empty
         skid_valid   <= 1'b0;
      end else if (transfer) begin
         skid_valid   <= 1'b1;
         skid_pc      <= in_pc;
         skid_payload <= in_payload;
      end
   end

   // in_ready tracks the next value of skid_valid, computed from the same conditions.
   always_ff @(posedge clk) begin
      if (reset || req || flush) begin
         in_ready_q <= 1'b1;
      end else if (main_free) begin
         in_ready_q <= 1'b1;
      end else if (transfer) begin
         in_ready_q <= 1'b0;
      end
   end

   // Saturating count of cycles where a valid output is back-pressured.
   // Only reset clears it; flush and req leave it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (main_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_ONE;
      end
   end

   // Drive the outputs straight from the flops.
   always_comb begin
      in_ready    = in_ready_q;
      out_valid   = main_valid;
      out_pc      = main_pc;
      out_payload = main_payload;
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg.
// The reference model treats the stage as an ordered queue that holds at most 2 entries.
// Two DUTs share the same stimulus: one with CNT_W=16 and one with CNT_W=4.
module tb_pipe_stage_reg;
  localparam int          DW  = 32;
  localparam int          NF  = 4;
  localparam int          PW  = DW * NF;
  localparam logic [31:0] EXC = 32'h00004180;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          out_ready;
  logic          flush;
  logic          req;
  logic [31:0]   in_pc;
  logic [PW-1:0] in_payload;

  logic          in_ready,  out_valid;
  logic [31:0]   out_pc;
  logic [PW-1:0] out_payload;
  logic [15:0]   stall_cnt;

  logic          in_ready4, out_valid4;
  logic [31:0]   out_pc4;
  logic [PW-1:0] out_payload4;
  logic [3:0]    stall_cnt4;

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  // ---------------- DUTs ----------------
  pipe_stage_reg #(.DATA_W(DW), .NUM_FIELDS(NF), .EXC_PC(EXC), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_payload(in_payload), .flush(flush), .req(req),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_payload(out_payload), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .NUM_FIELDS(NF), .EXC_PC(EXC), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_pc(in_pc), .in_payload(in_payload), .flush(flush), .req(req),
    .out_valid(out_valid4), .out_ready(out_ready), .out_pc(out_pc4),
    .out_payload(out_payload4), .stall_cnt(stall_cnt4)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net: stop the run if the directed sequence never finishes.
  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]   pc;
    logic [PW-1:0] pay;
  } ent_t;

  ent_t          m_q[$];    // held entries, oldest first; at most 2
  logic [31:0]   m_pc;      // PC shown when nothing is held
  logic [PW-1:0] m_pay;     // payload shown when nothing is held
  int            m_cnt16;
  int            m_cnt4;

  // Update the model on each active edge from the inputs as they stand before the edge.
  always @(posedge clk) begin
    ent_t e;
    bit   acc;
    if (m_q.size() > 0 && !out_ready) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (reset) begin
      m_q.delete();
      m_pc = 32'h0; m_pay = '0; m_cnt16 = 0; m_cnt4 = 0;
    end else if (req) begin
      m_q.delete();
      m_pc = EXC; m_pay = '0;
    end else if (flush) begin
      m_q.delete();
      m_pc = in_pc; m_pay = '0;
    end else begin
      acc = in_valid && (m_q.size() < 2);
      if (m_q.size() > 0 && out_ready) begin
        e = m_q.pop_front();
        m_pc = e.pc; m_pay = e.pay;
      end
      if (acc) begin
        e.pc = in_pc; e.pay = in_payload;
        m_q.push_back(e);
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("out_valid",    out_valid,    m_q.size() > 0);
      check("out_pc",       out_pc,       m_q.size() > 0 ? m_q[0].pc  : m_pc);
      check("out_payload",  out_payload,  m_q.size() > 0 ? m_q[0].pay : m_pay);
      check("in_ready",     in_ready,     m_q.size() < 2);
      check("stall_cnt",    stall_cnt,    m_cnt16);
      check("out_valid4",   out_valid4,   m_q.size() > 0);
      check("out_pc4",      out_pc4,      m_q.size() > 0 ? m_q[0].pc  : m_pc);
      check("out_payload4", out_payload4, m_q.size() > 0 ? m_q[0].pay : m_pay);
      check("in_ready4",    in_ready4,    m_q.size() < 2);
      check("stall_cnt4",   stall_cnt4,   m_cnt4);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [23:0] vpat;
  logic [23:0] rpat;
  logic [31:0] word;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = 32'h0; in_payload = '0;
    out_ready = 1'b0; flush = 1'b0; req = 1'b0;
    @(negedge clk); @(negedge clk);
    check_en = 1'b1;

    // state straight after reset
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_payload", out_payload, '0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_stall_cnt", stall_cnt, 16'h0);

    // a single entry appears one cycle after it is accepted
    reset = 1'b0; in_valid = 1'b1; in_pc = 32'h3000;
    in_payload = {4{32'hA5A5A5A5}}; out_ready = 1'b1;
    @(negedge clk);
    check("lat_out_valid", out_valid, 1'b1);
    check("lat_out_pc", out_pc, 32'h3000);
    check("lat_out_payload", out_payload, {4{32'hA5A5A5A5}});

    // back-pressure with two entries back to back, then release
    in_pc = 32'h3004; in_payload = {4{32'h11110004}};
    @(negedge clk);
    check("bp_main_3004", out_pc, 32'h3004);
    out_ready = 1'b0; in_pc = 32'h3008; in_payload = {4{32'h11110008}};
    @(negedge clk);
    check("bp_hold_3004", out_pc, 32'h3004);
    check("bp_in_ready0", in_ready, 1'b0);
    check("bp_stall1", stall_cnt, 16'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_stall2", stall_cnt, 16'd2);
    check("bp_still_3004", out_pc, 32'h3004);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_next_3008", out_pc, 32'h3008);
    check("bp_next_valid", out_valid, 1'b1);
    check("bp_in_ready1", in_ready, 1'b1);
    @(negedge clk);
    check("bp_empty", out_valid, 1'b0);

    // a req while both entries are full redirects the PC and clears both entries
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h3010; in_payload = {4{32'h22220010}};
    @(negedge clk);
    in_pc = 32'h3014; in_payload = {4{32'h22220014}};
    @(negedge clk);
    check("req_full", in_ready, 1'b0);
    in_pc = 32'h3018; req = 1'b1;
    @(negedge clk);
    req = 1'b0; in_valid = 1'b0;
    check("req_out_valid", out_valid, 1'b0);
    check("req_out_pc", out_pc, EXC);
    check("req_payload", out_payload, '0);
    check("req_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check("req_no_revive", out_valid, 1'b0);

    // a flush keeps in_pc, and the entry offered with it is never delivered
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h301C; in_payload = {4{32'h3333001C}};
    @(negedge clk);
    flush = 1'b1; in_pc = 32'h300C; in_payload = {4{32'h3333000C}};
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_out_pc", out_pc, 32'h300C);
    check("flush_payload", out_payload, '0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("flush_not_later", out_valid, 1'b0);
    check("flush_pc_kept", out_pc, 32'h300C);

    // req beats flush when both arrive in the same cycle
    in_valid = 1'b1; in_pc = 32'h3020; req = 1'b1; flush = 1'b1;
    @(negedge clk);
    req = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("reqflush_pc", out_pc, EXC);
    check("reqflush_valid", out_valid, 1'b0);

    // reset beats req, and reset clears both entries while they are full
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h3024;
    @(negedge clk);
    in_pc = 32'h3028;
    @(negedge clk);
    check("rstfull_in_ready", in_ready, 1'b0);
    reset = 1'b1; req = 1'b1; in_pc = 32'h302C;
    @(negedge clk);
    reset = 1'b0; req = 1'b0; in_valid = 1'b0;
    check("rstreq_out_valid", out_valid, 1'b0);
    check("rstreq_out_pc", out_pc, 32'h0);
    check("rstreq_in_ready", in_ready, 1'b1);
    check("rstreq_stall", stall_cnt, 16'h0);

    // the 4-bit stall counter saturates over 20 stalled cycles
    in_valid = 1'b1; in_pc = 32'h3030; in_payload = {4{32'h44440030}};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("sat_cnt4", stall_cnt4, 4'hF);
    check("sat_cnt16", stall_cnt, 16'd20);
    check("sat_pc", out_pc4, 32'h3030);
    out_ready = 1'b1;
    @(negedge clk);

    // mixed valid/ready pattern; the model checks ordering and that nothing is lost
    vpat = 24'b1111_0111_1011_1111_1101_1110;
    rpat = 24'b0011_1001_0110_0100_1110_0011;
    for (int i = 0; i < 24; i++) begin
      word       = 32'hC0DE0000 + 32'(i);
      in_valid   = vpat[i];
      out_ready  = rpat[i];
      in_pc      = 32'h4000 + 32'(i * 4);
      in_payload = {word, ~word, word ^ 32'h0F0F0F0F, 32'(i)};
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("drain_empty", out_valid, 1'b0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
